// File: rtl/byte_bus_mem_bridge.sv
// rtl/byte_bus_mem_bridge.sv - byte-serial 10-phase frame target with 32-bit register-file memory
// Optional feature macro: FRAME_SYNC_EN (adds frame_sync realignment input)
module byte_bus_mem_bridge #(
  parameter int ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FRAME_SYNC_EN
  input  logic        frame_sync,
`endif
  input  logic [7:0]  addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [3:0]  phase,
  output logic        err,
  output logic [15:0] txn_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem [DEPTH];
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 wr;
  logic [ADDR_BITS-1:0] idx;
  logic                 in_range;
  logic [31:0]          rd_val;
  logic                 sync;
  logic                 mem_we;

`ifdef FRAME_SYNC_EN
  assign sync = frame_sync;
`else
  assign sync = 1'b0;
`endif

  assign idx      = addr[ADDR_BITS+1:2];
  assign in_range = (addr[31:ADDR_BITS+2] == '0);
  assign rd_val   = in_range ? mem[idx] : 32'd0;
  assign mem_we   = rst_n && !sync && (phase == 4'd5) && addr_in[0] && in_range;

  // Word access only: the byte offset bits are captured but never used.
  logic unused_byte_offset;
  assign unused_byte_offset = &{1'b0, addr[1:0]};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= 4'd0;
      addr      <= 32'd0;
      wdata     <= 32'd0;
      rdata     <= 32'd0;
      wr        <= 1'b0;
      data_out  <= 8'd0;
      data_oe   <= 1'b0;
      err       <= 1'b0;
      txn_count <= 16'd0;
    end else if (sync) begin
      phase    <= 4'd1;
      data_out <= 8'd0;
      data_oe  <= 1'b0;
    end else begin
      phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
      case (phase)
        4'd1: begin addr[7:0]   <= addr_in; wdata[7:0]   <= data_in; end
        4'd2: begin addr[15:8]  <= addr_in; wdata[15:8]  <= data_in; end
        4'd3: begin addr[23:16] <= addr_in; wdata[23:16] <= data_in; end
        4'd4: begin addr[31:24] <= addr_in; wdata[31:24] <= data_in; end
        4'd5: begin
          wr        <= addr_in[0];
          txn_count <= txn_count + 16'd1;
          if (!in_range) begin
            err <= 1'b1;
          end
          if (addr_in[0]) begin
            data_out <= 8'd0;
            data_oe  <= 1'b0;
          end else begin
            rdata    <= rd_val;
            data_out <= rd_val[7:0];
            data_oe  <= 1'b1;
          end
        end
        4'd6: data_out <= wr ? 8'd0 : rdata[15:8];
        4'd7: data_out <= wr ? 8'd0 : rdata[23:16];
        4'd8: data_out <= wr ? 8'd0 : rdata[31:24];
        4'd9: begin
          data_out <= 8'd0;
          data_oe  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_bus_mem_bridge.sv
// tb/tb_byte_bus_mem_bridge.sv - randomized frame bench for byte_bus_mem_bridge against a word-level model
module tb_byte_bus_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr_in;
  logic [7:0]  data_in;
  wire  [7:0]  data_out;
  wire         data_oe;
  wire  [3:0]  phase;
  wire         err;
  wire  [15:0] txn_count;
`ifdef FRAME_SYNC_EN
  logic        frame_sync = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [16];
  logic        m_err;
  logic [15:0] m_txn;

  always #5 clk = ~clk;

  byte_bus_mem_bridge #(.ADDR_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FRAME_SYNC_EN
    .frame_sync(frame_sync),
`endif
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .phase     (phase),
    .err       (err),
    .txn_count (txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one frame from phase first_p (called at a negedge); abort_p / sync_p < 0 disable.
  task automatic frame(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input int first_p, input int abort_p, input int sync_p);
    logic [31:0] rv;
    logic        inr;
    logic [3:0]  ix;
    rv = 32'd0;
    for (int p = first_p; p <= 9; p++) begin
      chk("phase", {28'd0, phase}, p);
      addr_in = 8'($urandom);
      data_in = 8'($urandom);
      if (p >= 1 && p <= 4) begin
        addr_in = a[8*(p-1) +: 8];
        data_in = d[8*(p-1) +: 8];
      end
      if (p == 5) addr_in[0] = w;
      if (p >= 6) begin
        chk("data_oe", {31'd0, data_oe}, {31'd0, !w});
        chk("data_out", {24'd0, data_out}, w ? 32'd0 : {24'd0, rv[8*(p-6) +: 8]});
      end
      if (p == abort_p) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_txn = 16'd0;
        m_err = 1'b0;
        chk("rst_phase", {28'd0, phase}, 0);
        chk("rst_txn", {16'd0, txn_count}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_oe", {31'd0, data_oe}, 0);
        return;
      end
`ifdef FRAME_SYNC_EN
      if (p == sync_p) begin
        frame_sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_sync = 1'b0;
        chk("sync_phase", {28'd0, phase}, 1);
        chk("sync_oe", {31'd0, data_oe}, 0);
        chk("sync_out", {24'd0, data_out}, 0);
        chk("sync_txn", {16'd0, txn_count}, {16'd0, m_txn});
        return;
      end
`endif
      if (p == 5) begin
        inr = (a[31:6] == 26'd0);
        ix  = a[5:2];
        if (!inr) m_err = 1'b1;
        if (w) begin
          if (inr) m_mem[ix] = d;
        end else begin
          rv = inr ? m_mem[ix] : 32'd0;
        end
        m_txn = m_txn + 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("end_oe", {31'd0, data_oe}, 0);
    chk("end_out", {24'd0, data_out}, 0);
    chk("end_err", {31'd0, err}, {31'd0, m_err});
    chk("end_txn", {16'd0, txn_count}, {16'd0, m_txn});
  endtask

  initial begin
    logic [31:0] a;
    rst_n   = 1'b0;
    addr_in = 8'd0;
    data_in = 8'd0;
    m_err   = 1'b0;
    m_txn   = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_phase", {28'd0, phase}, 0);
    chk("reset_out", {24'd0, data_out}, 0);
    chk("reset_oe", {31'd0, data_oe}, 0);
    chk("reset_err", {31'd0, err}, 0);
    chk("reset_txn", {16'd0, txn_count}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) frame(32'(i * 4), $urandom, 1'b1, 0, -1, -1);

    // T1: write then read back byte-serially
    frame(32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 0, -1, -1);
    frame(32'h0000_0008, $urandom, 1'b0, 0, -1, -1);
    chk("t1_txn", {16'd0, txn_count}, 18);

    // T2: out-of-range read, err sticky through a good write
    frame(32'h0000_0100, $urandom, 1'b0, 0, -1, -1);
    chk("t2_err", {31'd0, err}, 1);
    frame(32'h0000_0004, $urandom, 1'b1, 0, -1, -1);
    chk("t2_err_sticky", {31'd0, err}, 1);

    // T3: reset during phase 3 of a write drops that write
    frame(32'h0000_0004, 32'h1122_3344, 1'b1, 0, -1, -1);
    frame(32'h0000_0004, 32'h5566_7788, 1'b1, 0, 3, -1);
    frame(32'h0000_0004, $urandom, 1'b0, 0, -1, -1);

    // T4: byte offset ignored
    frame(32'h0000_000F, 32'hCAFE_F00D, 1'b1, 0, -1, -1);
    frame(32'h0000_000C, $urandom, 1'b0, 0, -1, -1);
    frame(32'h0000_000F, $urandom, 1'b0, 0, -1, -1);

    for (int n = 0; n < 120; n++) begin
      a = {26'd0, 4'($urandom), 2'($urandom)};
      if ($urandom_range(0, 4) == 0) a = a | (32'd1 << (6 + $urandom_range(0, 25)));
      frame(a, $urandom, 1'($urandom), 0, -1, -1);
    end

    // T5: txn_count wrap
    force dut.txn_count = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.txn_count;
    m_txn = 16'hFFFF;
    frame(32'h0000_0000, $urandom, 1'b0, 1, -1, -1);
    chk("t5_wrap", {16'd0, txn_count}, 0);

`ifdef FRAME_SYNC_EN
    // T6: frame_sync mid read, then a normal frame
    frame(32'h0000_0008, $urandom, 1'b0, 0, -1, 7);
    frame(32'h0000_0008, $urandom, 1'b0, 1, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
